// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - pushbutton/switch conditioner with debounce and auto-repeat
//
// Synchronizes four raw asynchronous inputs. The two active-low keys are
// debounced and turned into single-cycle increment pulses: one on the press,
// one after REPEAT_DELAY, then one every REPEAT_PERIOD while the key is held.
// Key pulses are gated by the synchronized set-mode switch.
//
// Ports:
//   clk              system clock
//   reset            asynchronous active-low reset
//   key_hours_n      raw hours key, low = pressed
//   key_minutes_n    raw minutes key, low = pressed
//   mode_switch_raw  raw set-mode switch, high = set mode
//   hour_mode_raw    raw 12/24 switch, high = 12-hour
//   button_hours     one-cycle hours increment pulse
//   button_minutes   one-cycle minutes increment pulse
//   mode_switch      synchronized set-mode level
//   hour_mode_switch synchronized 12/24 level

module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_hours_n,
    input  logic key_minutes_n,
    input  logic mode_switch_raw,
    input  logic hour_mode_raw,
    output logic button_hours,
    output logic button_minutes,
    output logic mode_switch,
    output logic hour_mode_switch
);

    localparam int MAX_AB = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_C  = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
    localparam int CW     = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    // Switch synchronizers: bit 0 = set mode, bit 1 = 12/24.
    logic [1:0] sw_meta_q, sw_meta_d;
    logic [1:0] sw_sync_q, sw_sync_d;

    // Counts the first two edges after reset so the key synchronizers have
    // been filled with real samples before a key may be judged released.
    logic [1:0] settle_q, settle_d;
    logic       settle_done;

    logic [1:0] key_raw;
    logic [1:0] pulse_bits;

    assign key_raw     = {key_minutes_n, key_hours_n};
    assign settle_done = (settle_q == 2'd2);

    always_comb begin
        sw_meta_d = {hour_mode_raw, mode_switch_raw};
        sw_sync_d = sw_meta_q;
        settle_d  = settle_done ? settle_q : settle_q + 2'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_meta_q <= 2'b00;
            sw_sync_q <= 2'b00;
            settle_q  <= 2'd0;
        end else begin
            sw_meta_q <= sw_meta_d;
            sw_sync_q <= sw_sync_d;
            settle_q  <= settle_d;
        end
    end

    assign mode_switch      = sw_sync_q[0];
    assign hour_mode_switch = sw_sync_q[1];

    for (genvar g = 0; g < 2; g++) begin : g_key
        logic          key_meta_q, key_meta_d;
        logic          key_sync_q, key_sync_d;
        logic          deb_q, deb_d;
        logic [CW-1:0] db_cnt_q, db_cnt_d;
        logic          armed_q, armed_d;
        state_t        state_q, state_d;
        logic [CW-1:0] tmr_q, tmr_d;
        logic          fire_q, fire_d;
        logic          pulse_q, pulse_d;

        always_comb begin
            key_meta_d = key_raw[g];
            key_sync_d = key_meta_q;

            deb_d    = deb_q;
            db_cnt_d = '0;
            if (key_sync_q != deb_q) begin
                if (db_cnt_q == DB_LAST) begin
                    deb_d = key_sync_q;
                end else begin
                    db_cnt_d = db_cnt_q + CW'(1);
                end
            end

            // A key held through reset must be seen released (both raw and
            // debounced) before a press is allowed to start the FSM.
            armed_d = armed_q | (settle_done & key_sync_q & deb_q);

            state_d = state_q;
            tmr_d   = tmr_q;
            fire_d  = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    tmr_d = '0;
                    if (!deb_q && armed_q) begin
                        state_d = ST_HOLD;
                        fire_d  = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (deb_q) begin
                        state_d = ST_IDLE;
                        tmr_d   = '0;
                    end else if (tmr_q == RD_LAST) begin
                        state_d = ST_REPEAT;
                        tmr_d   = '0;
                        fire_d  = 1'b1;
                    end else begin
                        tmr_d = tmr_q + CW'(1);
                    end
                end
                ST_REPEAT: begin
                    if (deb_q) begin
                        state_d = ST_IDLE;
                        tmr_d   = '0;
                    end else if (tmr_q == RP_LAST) begin
                        tmr_d  = '0;
                        fire_d = 1'b1;
                    end else begin
                        tmr_d = tmr_q + CW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    tmr_d   = '0;
                end
            endcase

            // The FSM keeps running in run mode; only the output is gated.
            pulse_d = fire_q & sw_sync_q[0];
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                key_meta_q <= 1'b1;
                key_sync_q <= 1'b1;
                deb_q      <= 1'b1;
                db_cnt_q   <= '0;
                armed_q    <= 1'b0;
                state_q    <= ST_IDLE;
                tmr_q      <= '0;
                fire_q     <= 1'b0;
                pulse_q    <= 1'b0;
            end else begin
                key_meta_q <= key_meta_d;
                key_sync_q <= key_sync_d;
                deb_q      <= deb_d;
                db_cnt_q   <= db_cnt_d;
                armed_q    <= armed_d;
                state_q    <= state_d;
                tmr_q      <= tmr_d;
                fire_q     <= fire_d;
                pulse_q    <= pulse_d;
            end
        end

        assign pulse_bits[g] = pulse_q;
    end

    assign button_hours   = pulse_bits[0];
    assign button_minutes = pulse_bits[1];

endmodule
